// File: rtl/illegal_instruction_trap_sequencer.sv
// Illegal-instruction trap sequencer.
// Captures the offending PC (and, with ILLEGAL_TVAL_EN defined, the raw
// instruction word), flushes younger work, waits for the pipeline to drain,
// writes mepc/mcause/mtval through a valid/ready CSR port and then redirects
// fetch to the direct-mode trap vector.
// Optional build macro: ILLEGAL_TVAL_EN (mtval = captured instruction word).
module illegal_instruction_trap_sequencer #(
  parameter int unsigned MCAUSE_ILLEGAL = 2,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic               issue_illegal,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_instruction,
  output logic               issue_ready,
  output logic               flush,
  input  logic               pipeline_idle,
  input  logic [31:0]        mtvec,
  output logic               csr_write_valid,
  input  logic               csr_write_ready,
  output logic [31:0]        csr_mepc,
  output logic [31:0]        csr_mcause,
  output logic [31:0]        csr_mtval,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy,
  output logic [COUNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CSR_WR,
    REDIRECT
  } state_t;

  state_t              state;
  logic [31:0]         mepc_q;
  logic                flush_q;
  logic                redirect_q;
  logic [31:0]         redirect_pc_q;
  logic [COUNT_W-1:0]  count_q;
`ifdef ILLEGAL_TVAL_EN
  logic [31:0]         tval_q;
`endif

  // Trap sequencing FSM with registered pulse outputs, capture and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mepc_q        <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      count_q       <= '0;
`ifdef ILLEGAL_TVAL_EN
      tval_q        <= '0;
`endif
    end else begin
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid && issue_illegal) begin
            mepc_q  <= issue_pc;
`ifdef ILLEGAL_TVAL_EN
            tval_q  <= issue_instruction;
`endif
            flush_q <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipeline_idle) begin
            state <= CSR_WR;
          end
        end
        CSR_WR: begin
          if (csr_write_ready) begin
            // Direct mode only: mode bits are masked off the vector
            redirect_pc_q <= mtvec & 32'hFFFF_FFFC;
            redirect_q    <= 1'b1;
            state         <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (count_q != '1) begin
            count_q <= count_q + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and CSR port decoded from registered state only
  always_comb begin
    issue_ready     = (state == IDLE);
    busy            = (state != IDLE);
    csr_write_valid = (state == CSR_WR);
    csr_mepc        = '0;
    csr_mcause      = '0;
    csr_mtval       = '0;
    if (state == CSR_WR) begin
      csr_mepc   = mepc_q;
      csr_mcause = {1'b0, 31'(MCAUSE_ILLEGAL)};
`ifdef ILLEGAL_TVAL_EN
      csr_mtval  = tval_q;
`endif
    end
  end

`ifndef ILLEGAL_TVAL_EN
  logic unused_instruction;
  assign unused_instruction = ^issue_instruction;
`endif

  assign flush          = flush_q;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_count     = count_q;

endmodule

// File: doc/illegal_instruction_trap_sequencer.md
# illegal_instruction_trap_sequencer

Sequences the precise trap for an instruction the decode-stage illegal-instruction check has flagged. It sits between decode/issue and the CSR unit. It captures the offending PC and instruction word, flushes younger work, and waits for the pipeline to drain. It then writes mepc/mcause/mtval through a valid/ready CSR port and redirects fetch to the trap vector.

## Interface
Parameters:
- MCAUSE_ILLEGAL, 2, exception code written to mcause; zero-extended to 32 bits, bit 31 (interrupt) always 0
- COUNT_W, 16, width of the saturating trap counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_illegal  in  1  illegal flag from decode check; qualified by issue_valid
- issue_pc  in  32  PC of presented instruction
- issue_instruction  in  32  raw instruction word
- issue_ready  out  1  decode may issue; low while a trap is sequenced
- flush  out  1  one-cycle pulse; kill all in-flight younger instructions
- pipeline_idle  in  1  no instruction outstanding in any execution unit
- mtvec  in  32  current trap vector CSR value
- csr_write_valid  out  1  trap CSR update request
- csr_write_ready  in  1  CSR unit accepts update
- csr_mepc  out  32  value for mepc
- csr_mcause  out  32  value for mcause
- csr_mtval  out  32  value for mtval
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- busy  out  1  state != IDLE
- trap_count  out  COUNT_W  number of completed traps, saturating

## Operation
- States: IDLE, DRAIN, CSR_WR, REDIRECT.
- IDLE: issue_ready=1. The block does not consume legal instructions; they pass freely.
- IDLE exit: on issue_valid & issue_illegal, register issue_pc into mepc and issue_instruction into the instruction capture, then go to DRAIN.
- DRAIN: flush=1 for the first DRAIN cycle only.
  - Stay in DRAIN while pipeline_idle=0.
  - On pipeline_idle=1 (sampled every DRAIN cycle, including the first), go to CSR_WR.
- CSR_WR: csr_write_valid=1. csr_mepc, csr_mcause and csr_mtval are held stable until the handshake. valid never drops before ready.
  - On valid&ready: register redirect_pc = {mtvec[31:2],2'b00} (direct mode only), then go to REDIRECT.
- REDIRECT: redirect_valid=1 for exactly one cycle. trap_count increments and saturates at all-ones. Next state is IDLE.
- issue_illegal without issue_valid is ignored.
- A new illegal instruction presented while the block is not in IDLE is not captured, because issue_ready=0.
- mtvec changes after the CSR_WR handshake do not affect redirect_pc.
- csr_mepc, csr_mcause and csr_mtval read as 0 whenever csr_write_valid=0.

## Timing
- Reset values: state IDLE, issue_ready=1, flush=0, csr_write_valid=0, csr_mepc/csr_mcause/csr_mtval=0, redirect_valid=0, redirect_pc=0, busy=0, trap_count=0.
- Best case, with pipeline_idle=1 and csr_write_ready=1 throughout:
  - T0: capture in IDLE.
  - T1: DRAIN, flush=1.
  - T2: CSR_WR, handshake.
  - T3: REDIRECT.
  - T4: IDLE, issue_ready=1.
  - Total 4 cycles from capture back to IDLE.
- issue_ready and busy are decoded from registered state, with no combinational path from issue_* inputs.
- Each cycle of csr_write_ready=0 in CSR_WR adds one cycle. Each cycle of pipeline_idle=0 in DRAIN adds one cycle.
- Reset asserted in any state returns to IDLE immediately. An in-progress CSR request is withdrawn, no redirect is issued, and trap_count clears.

## Configuration
- ILLEGAL_TVAL_EN defined: csr_mtval = captured instruction word. The capture register is implemented.
- ILLEGAL_TVAL_EN undefined: csr_mtval = 0 constant. The instruction capture register is removed.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then issue_valid=1, issue_illegal=1, pc=0x0000_1000, instr=0xFFFF_FFFF, mtvec=0x0000_0201, idle and ready tied 1.
  - Required: flush at T1; CSR write at T2 with mepc=0x1000, mcause=0x2, mtval=0xFFFF_FFFF (or 0 without ILLEGAL_TVAL_EN); redirect_pc=0x0000_0200 at T3; trap_count=1.
- Hold pipeline_idle=0 for 5 cycles after capture.
  - Required: flush is high exactly one cycle; the block stays in DRAIN 6 cycles; CSR_WR is entered on the cycle after idle rises.
- csr_write_ready=0 for 3 cycles, and mtvec changed during the stall.
  - Required: csr_write_valid is held with stable values; redirect_pc uses mtvec at the handshake cycle; a change to mtvec in REDIRECT is ignored.
- Stream of legal instructions with issue_illegal=0.
  - Required: issue_ready stays 1; no flush, CSR write or redirect occurs.
- Assert rst in CSR_WR mid-stall.
  - Required: all outputs return to reset values asynchronously; no redirect follows.
- Preload 0xFFFE traps and complete 3 more.
  - Required: trap_count reads 0xFFFF and holds.
